// File: rtl/host_regfile_ctrl_if.sv
// Host bus bundle for host_regfile_ctrl: address, select, active-low strobes,
// write data, and the acknowledge/error/read-data return path.
//
// Handshake: the host opens an access by driving a falling edge on exactly
// one strobe (rd_n or wr_n) while sel=1, keeps addr/wdata/strobe stable, and
// waits for rdy. rdy is high for a fixed number of cycles; read data is valid
// (rdata_oe=1) from the first rdy cycle until the strobe has been released.
// The access closes when the host raises the strobe again. The host must not
// start a new access until rdy has been seen and the strobe released. err is
// a one-cycle pulse flagging a protocol or access violation.
interface host_regfile_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              sel;
    logic              rd_n;
    logic              wr_n;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_oe;
    logic              rdy;
    logic              err;

    modport master (
        output addr, sel, rd_n, wr_n, wdata,
        input  rdata, rdata_oe, rdy, err
    );

    modport slave (
        input  addr, sel, rd_n, wr_n, wdata,
        output rdata, rdata_oe, rdy, err
    );
endinterface

// File: rtl/host_regfile_ctrl.sv
// Host-mapped register file: read-only live status window at the low
// addresses, writable config registers above it, counted wait-state/rdy
// handshake, and an err pulse on protocol or access violations.
module host_regfile_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int RO_LIMIT    = 8,
    parameter int WAIT_STATES = 1,
    parameter int RDY_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    host_regfile_ctrl_if.slave        bus,
    input  logic [RO_LIMIT*DATA_W-1:0] sts_i,
    output logic [DEPTH*DATA_W-1:0]   cfg_o,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ACK  = 3'd2,
        S_HOLD = 3'd3,
        S_GAP  = 3'd4,
        S_ERRW = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     rd_now_q, rd_now_d, rd_prev_q, rd_prev_d;
    logic                     wr_now_q, wr_now_d, wr_prev_q, wr_prev_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     is_wr_q, is_wr_d;
    logic                     rel_q, rel_d;
    logic [DATA_W-1:0]        wbuf_q, wbuf_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic                     oe_q, oe_d;
    logic                     err_q, err_d;
    logic [DEPTH*DATA_W-1:0]  regs_q, regs_d;
    logic [DEPTH*DATA_W-1:0]  cfg_q, cfg_d;

    logic                     rd_fall, wr_fall, start, both_low;
    logic                     strobe_hi, released;
    logic [ADDR_W-1:0]        acc_addr;
    logic                     acc_in_range, acc_ro;
    logic [DATA_W-1:0]        rd_val, commit_val;

    // Strobe edge detect, address decode and read-data select.
    always_comb begin
        rd_fall      = rd_prev_q & ~rd_now_q;
        wr_fall      = wr_prev_q & ~wr_now_q;
        start        = (rd_fall | wr_fall) & bus.sel;
        both_low     = ~rd_now_q & ~wr_now_q;
        // With zero wait states the read value is chosen on the same edge
        // that latches the address, so decode from the live bus in IDLE.
        acc_addr     = (state_q == S_IDLE) ? bus.addr : addr_q;
        acc_in_range = {1'b0, acc_addr} < (ADDR_W+1)'(DEPTH);
        acc_ro       = acc_addr < ADDR_W'(RO_LIMIT);
        strobe_hi    = is_wr_q ? bus.wr_n : bus.rd_n;
        released     = strobe_hi | rel_q;
        // An early release has already captured wdata in wbuf_q.
        commit_val   = rel_q ? wbuf_q : bus.wdata;
        rd_val       = '0;
        for (int i = 0; i < RO_LIMIT; i++) begin
            if (acc_addr == ADDR_W'(i)) rd_val = sts_i[i*DATA_W +: DATA_W];
        end
        for (int i = RO_LIMIT; i < DEPTH; i++) begin
            if (acc_addr == ADDR_W'(i)) rd_val = regs_q[i*DATA_W +: DATA_W];
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (both_low)              state_d = S_ERRW;
                    else if (WAIT_STATES == 0) state_d = S_ACK;
                    else                       state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'(WAIT_STATES - 1)) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                if (cnt_q == 4'(RDY_CYCLES - 1)) state_d = S_HOLD;
                else                              cnt_d   = cnt_q + 4'd1;
            end
            S_HOLD:  if (released) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            S_ERRW:  if (rd_now_q & wr_now_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: latching, read data, commit and error pulses.
    always_comb begin
        rd_now_d  = bus.rd_n;
        rd_prev_d = rd_now_q;
        wr_now_d  = bus.wr_n;
        wr_prev_d = wr_now_q;
        addr_d    = addr_q;
        is_wr_d   = is_wr_q;
        rel_d     = rel_q;
        wbuf_d    = wbuf_q;
        rdata_d   = rdata_q;
        oe_d      = oe_q;
        err_d     = 1'b0;
        regs_d    = regs_q;
        cfg_d     = regs_q;
        case (state_q)
            S_IDLE: begin
                rel_d = 1'b0;
                if (start) begin
                    if (both_low) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = bus.addr;
                        is_wr_d = wr_fall;
                    end
                end
            end
            S_WAIT, S_ACK: begin
                if (strobe_hi && !rel_q) begin
                    rel_d  = 1'b1;
                    wbuf_d = bus.wdata;
                end
            end
            S_HOLD: begin
                if (released) begin
                    rdata_d = '0;
                    oe_d    = 1'b0;
                    if (is_wr_q) begin
                        if (acc_in_range && !acc_ro) begin
                            for (int i = RO_LIMIT; i < DEPTH; i++) begin
                                if (addr_q == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = commit_val;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
        // Read data appears together with the first rdy cycle.
        if (state_d == S_ACK && state_q != S_ACK && !is_wr_d) begin
            rdata_d = rd_val;
            oe_d    = 1'b1;
            err_d   = !acc_in_range;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers; strobe history resets to the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_now_q  <= 1'b1;
            rd_prev_q <= 1'b1;
            wr_now_q  <= 1'b1;
            wr_prev_q <= 1'b1;
            addr_q    <= '0;
            is_wr_q   <= 1'b0;
            rel_q     <= 1'b0;
            wbuf_q    <= '0;
            rdata_q   <= '0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            regs_q    <= '0;
            cfg_q     <= '0;
        end else begin
            rd_now_q  <= rd_now_d;
            rd_prev_q <= rd_prev_d;
            wr_now_q  <= wr_now_d;
            wr_prev_q <= wr_prev_d;
            addr_q    <= addr_d;
            is_wr_q   <= is_wr_d;
            rel_q     <= rel_d;
            wbuf_q    <= wbuf_d;
            rdata_q   <= rdata_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
            regs_q    <= regs_d;
            cfg_q     <= cfg_d;
        end
    end

    // Output decode: rdy is high for exactly the cycles spent in ACK.
    always_comb begin
        bus.rdy      = (state_q == S_ACK);
        bus.rdata    = rdata_q;
        bus.rdata_oe = oe_q;
        bus.err      = err_q;
        cfg_o        = cfg_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_host_regfile_ctrl.sv
// Bench for host_regfile_ctrl: two instances (default timing, and zero wait
// states / single-cycle rdy / 20 registers) sharing one host driver.
module tb_host_regfile_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] addr;
    logic       sel, rd_n, wr_n;
    logic [7:0] wdata;
    int         cur;

    host_regfile_ctrl_if #(.ADDR_W(5), .DATA_W(8)) if_a ();
    host_regfile_ctrl_if #(.ADDR_W(5), .DATA_W(8)) if_b ();

    assign if_a.addr  = addr;
    assign if_a.sel   = sel && (cur == 0);
    assign if_a.rd_n  = rd_n;
    assign if_a.wr_n  = wr_n;
    assign if_a.wdata = wdata;
    assign if_b.addr  = addr;
    assign if_b.sel   = sel && (cur == 1);
    assign if_b.rd_n  = rd_n;
    assign if_b.wr_n  = wr_n;
    assign if_b.wdata = wdata;

    logic [63:0]  sts_a = {8{8'hA5}};
    logic [63:0]  sts_b = {8{8'h5C}};
    logic [255:0] cfg_a;
    logic [159:0] cfg_b;
    logic [2:0]   st_a, st_b;

    host_regfile_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RO_LIMIT(8),
                        .WAIT_STATES(1), .RDY_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave), .sts_i(sts_a),
        .cfg_o(cfg_a), .dbg_state(st_a));

    host_regfile_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(20), .RO_LIMIT(8),
                        .WAIT_STATES(0), .RDY_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave), .sts_i(sts_b),
        .cfg_o(cfg_b), .dbg_state(st_b));

    logic       o_rdy, o_oe, o_err;
    logic [7:0] o_rdata;
    logic [2:0] o_state;
    always_comb begin
        o_rdy   = (cur == 1) ? if_b.rdy      : if_a.rdy;
        o_oe    = (cur == 1) ? if_b.rdata_oe : if_a.rdata_oe;
        o_err   = (cur == 1) ? if_b.err      : if_a.err;
        o_rdata = (cur == 1) ? if_b.rdata    : if_a.rdata;
        o_state = (cur == 1) ? st_b          : st_a;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [255:0] exp_cfg;

    int         r_first, r_len, r_err, r_state;
    logic       r_oe, r_oe_after;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cfg(input string name);
        n_cmp++;
        if (cfg_a !== exp_cfg) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, cfg_a, exp_cfg);
        end
    endtask

    // Drive one access, pop the scoreboard on the first rdy cycle, release
    // the strobe once rdy has dropped, and watch two cycles past release.
    task automatic access(input bit wr, input logic [4:0] a, input logic [7:0] d);
        bit seen, released;
        int rel_k;
        @(negedge clk);
        addr = a; wdata = d; sel = 1'b1;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        r_first = -1; r_len = 0; r_err = 0; r_state = -1; r_oe = 1'b0; r_oe_after = 1'b1;
        seen = 1'b0; released = 1'b0; rel_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (o_err) r_err++;
            if (o_rdy) begin
                if (!seen) begin
                    seen = 1'b1; r_first = k; r_oe = o_oe;
                    if (!wr) begin
                        if (exp_q.size() == 0) check("rdata_no_expect", o_rdata, 32'hFFFF_FFFF);
                        else check("rdata", o_rdata, exp_q.pop_front());
                    end
                end
                r_len++;
            end
            if (released && k == rel_k + 1) begin
                r_state = o_state; r_oe_after = o_oe;
            end
            if (released && k == rel_k + 2) break;
            if (!released && seen && !o_rdy) begin
                rd_n = 1'b1; wr_n = 1'b1; released = 1'b1; rel_k = k;
            end
        end
        if (!released) begin
            rd_n = 1'b1; wr_n = 1'b1;
        end
        check("access_completed", released, 1);
        if (!wr && !seen && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic run(input bit wr, input logic [4:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input bit exp_err, input int ws, input int rc);
        if (!wr) exp_q.push_back(exp_rd);
        access(wr, a, d);
        check("rdy_start", r_first, ws + 2);
        check("rdy_len", r_len, rc);
        check("err_count", r_err, exp_err);
        check("oe_at_rdy", r_oe, !wr);
        check("oe_after_release", r_oe_after, 0);
        check("gap_after_release", r_state, 4);
    endtask

    typedef struct {
        bit         wr;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        bit         exp_err;
    } vec_t;

    vec_t vt[12];
    vec_t vb[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, rdys;
        rst = 1'b1; addr = '0; sel = 1'b0; rd_n = 1'b1; wr_n = 1'b1; wdata = '0; cur = 0;
        exp_cfg = '0;

        vt[0]  = '{0, 5'h00, 8'h00, 8'hA5, 0};
        vt[1]  = '{0, 5'h07, 8'h00, 8'hA5, 0};
        vt[2]  = '{0, 5'h08, 8'h00, 8'h00, 0};
        vt[3]  = '{1, 5'h10, 8'h3C, 8'h00, 0};
        vt[4]  = '{0, 5'h10, 8'h00, 8'h3C, 0};
        vt[5]  = '{1, 5'h03, 8'hFF, 8'h00, 1};
        vt[6]  = '{0, 5'h03, 8'h00, 8'hA5, 0};
        vt[7]  = '{1, 5'h1F, 8'h5A, 8'h00, 0};
        vt[8]  = '{0, 5'h1F, 8'h00, 8'h5A, 0};
        vt[9]  = '{1, 5'h08, 8'h11, 8'h00, 0};
        vt[10] = '{0, 5'h08, 8'h00, 8'h11, 0};
        vt[11] = '{0, 5'h10, 8'h00, 8'h3C, 0};

        vb[0] = '{0, 5'd25, 8'h00, 8'h00, 1};
        vb[1] = '{0, 5'd9,  8'h00, 8'h00, 0};
        vb[2] = '{1, 5'd10, 8'h42, 8'h00, 0};
        vb[3] = '{0, 5'd10, 8'h00, 8'h42, 0};
        vb[4] = '{0, 5'd3,  8'h00, 8'h5C, 0};

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset_rdata", o_rdata, 0);
        check("reset_oe", o_oe, 0);
        check("reset_rdy", o_rdy, 0);
        check("reset_err", o_err, 0);
        check_cfg("reset_cfg");
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", o_state, 0);

        // Sweep every address with the status window at 0xA5.
        for (int i = 0; i < 32; i++) run(0, 5'(i), 8'h00, (i < 8) ? 8'hA5 : 8'h00, 0, 1, 2);

        // Table of reads/writes with a config model.
        for (int i = 0; i < 12; i++) begin
            run(vt[i].wr, vt[i].a, vt[i].d, vt[i].exp, vt[i].exp_err, 1, 2);
            if (vt[i].wr && vt[i].a >= 5'd8) exp_cfg[vt[i].a*8 +: 8] = vt[i].d;
            check_cfg("cfg_after_vec");
        end

        // Both strobes fall together: err pulse, no rdy, parked until both high.
        @(negedge clk);
        addr = 5'h10; sel = 1'b1; rd_n = 1'b0; wr_n = 1'b0;
        errs = 0; rdys = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_err) errs++;
            if (o_rdy) rdys++;
        end
        check("both_low_err", errs, 1);
        check("both_low_rdy", rdys, 0);
        check("both_low_state", o_state, 5);
        rd_n = 1'b1;
        repeat (3) @(negedge clk);
        check("one_high_still_parked", o_state, 5);
        wr_n = 1'b1;
        repeat (3) @(negedge clk);
        check("both_high_idle", o_state, 0);
        check_cfg("cfg_after_both_low");
        run(0, 5'h10, 8'h00, 8'h3C, 0, 1, 2);

        // Reset in the middle of a write while rdy is high.
        @(negedge clk);
        addr = 5'h12; wdata = 8'h77; sel = 1'b1; wr_n = 1'b0;
        rdys = 0;
        for (int k = 0; k < 20 && !o_rdy; k++) @(negedge clk);
        check("rst_test_rdy_seen", o_rdy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_rdy", o_rdy, 0);
        check("async_rst_oe", o_oe, 0);
        check("async_rst_rdata", o_rdata, 0);
        check("async_rst_state", o_state, 0);
        wr_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cfg = '0;
        repeat (3) @(negedge clk);
        check_cfg("cfg_after_rst");
        run(0, 5'h12, 8'h00, 8'h00, 0, 1, 2);
        run(1, 5'h12, 8'h66, 8'h00, 0, 1, 2);
        exp_cfg[8'h12*8 +: 8] = 8'h66;
        check_cfg("cfg_write_after_rst");

        // Zero wait states, single-cycle rdy, 20 registers, back-to-back.
        @(negedge clk);
        cur = 1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) run(vb[i].wr, vb[i].a, vb[i].d, vb[i].exp, vb[i].exp_err, 0, 1);
        check("b_cfg_slot10", cfg_b[10*8 +: 8], 8'h42);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/host_regfile_ctrl.md
Name: host_regfile_ctrl

Overview:
- Synchronous, parametrised host-mapped register file. It succeeds the fixed 32x8 asynchronous-timing register block.
- A host interface with active-low rd/wr strobes is sampled on clk. A counted wait-state/rdy handshake replaces the delay-based AC timing.
- The low addresses form a read-only region that mirrors live hardware status. The remaining addresses are writable config registers exported to the datapath.
- Protocol and access violations are flagged on err.

Parameters:
- ADDR_W, 5: host address width.
- DATA_W, 8: register width.
- DEPTH, 32: implemented registers (1..2**ADDR_W).
- RO_LIMIT, 8: addresses 0..RO_LIMIT-1 are read-only status (0 < RO_LIMIT < DEPTH).
- WAIT_STATES, 1: idle cycles between strobe detect and rdy (0..15).
- RDY_CYCLES, 2: width of the rdy pulse in cycles (1..15).

Ports:
- clk, in, 1: single clock; all state changes on posedge.
- rst, in, 1: asynchronous, active-high reset.
- addr, in, ADDR_W: host address.
- sel, in, 1: host select, sampled with strobe detect.
- rd_n, in, 1: active-low read strobe.
- wr_n, in, 1: active-low write strobe.
- wdata, in, DATA_W: host write data.
- rdata, out, DATA_W: read data.
- rdata_oe, out, 1: read-data drive enable; the top-level tristate uses it.
- rdy, out, 1: access-acknowledge pulse.
- err, out, 1: one-cycle error pulse.
- sts_i, in, RO_LIMIT*DATA_W: live status; reg i = sts_i[i*DATA_W +: DATA_W].
- cfg_o, out, DEPTH*DATA_W: all register contents, same packing; RO slots read as 0.

Behaviour:
- Reset (rst=1, async):
  - State=IDLE.
  - rdata=0, rdata_oe=0, rdy=0, err=0, all writable regs=0.
  - Strobe history flops=1.
  - An access in flight is abandoned with no write committed.
- Strobe detect:
  - Registered history of rd_n/wr_n. A falling edge = prev 1, now 0.
  - Detection is acted on only in IDLE with sel=1. Falling edges with sel=0 are ignored.
- FSM states: IDLE, WAIT, ACK, HOLD, GAP, ERRW.
- IDLE:
  - Both strobes low at detect: err=1 for one cycle, then ERRW.
  - Else: latch addr and direction, then WAIT (or ACK if WAIT_STATES=0).
- WAIT: counts WAIT_STATES cycles, then ACK.
- ACK:
  - rdy=1 for exactly RDY_CYCLES cycles, then HOLD.
  - rdy first rises WAIT_STATES+1 cycles after the edge that sampled the strobe low.
- Read path:
  - On ACK entry, rdata and rdata_oe=1 are updated together with rdy rising.
  - Read value:
    - addr<RO_LIMIT: sts_i slot, captured on ACK entry.
    - RO_LIMIT<=addr<DEPTH: register.
    - addr>=DEPTH: 0, plus err pulse on ACK entry.
  - rdata is held constant through HOLD.
- HOLD:
  - Waits for the active strobe to be sampled high.
  - Read release: rdata_oe=0 and rdata=0 on the next edge.
  - Write release: commit wdata sampled on the release cycle, then GAP.
  - Write to addr<RO_LIMIT or addr>=DEPTH: no commit, err=1 for one cycle.
  - A strobe released before ACK completes is recorded; HOLD exits on its first cycle.
- GAP: one cycle, rdy=0, then IDLE. This guarantees a minimum one-cycle inter-access recovery.
- ERRW:
  - Wait until both strobes are high, then IDLE.
  - No rdy and no register change in this state.
- Address latching: addr changes after detect are ignored for that access. Latched addr is used for both data select and commit.
- cfg_o is registered and reflects a committed write on the edge after the commit edge.
- Only one access is in flight at a time. A strobe asserted outside IDLE is not queued.

Test Plan:
- Reset, then read each address 0..31 with sts_i=all 0xA5 → addr 0..7 return 0xA5; addr 8..31 return 0x00; cfg_o=0.
- Write 0x3C to addr 0x10, then read back → rdy high 2 cycles, starting 2 cycles after strobe sampled low; readback 0x3C; cfg_o[0x10 slot]=0x3C the cycle after wr_n rises; err=0.
- Write 0xFF to addr 0x03 → rdy pulse still given, err=1 one cycle at release, reg 3 still reads sts_i value, cfg_o unchanged.
- rd_n and wr_n fall on the same cycle with sel=1 → err one-cycle pulse, rdy never rises, no state change until both high. A following normal read completes correctly.
- rst asserted mid-write during ACK, with wr_n then released → no commit, all outputs 0 immediately (async). The next access works from IDLE.
- WAIT_STATES=0, RDY_CYCLES=1, DEPTH=20: read addr 25 → err pulse, rdata 0, rdy one cycle right after detect. Back-to-back reads are separated by a GAP cycle.
